// File: rtl/alu_exec_seq.sv
// RV32I execute-stage sequencer: accepts one R-type or I-type ALU op,
// computes it (serial 1-bit/cycle shifter when SERIAL_SHIFT=1) and holds
// the result until writeback accepts it.
module alu_exec_seq #(
    parameter int unsigned SERIAL_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        illegal
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] result_q;   // result, and the working register while shifting
    logic [4:0]  rd_q;
    logic        we_q;
    logic        ill_q;
    logic        vld_q;
    logic [4:0]  cnt_q;      // remaining serial shift steps
    logic        left_q;     // serial shift direction
    logic        arith_q;    // serial right shift replicates bit 31

    // Instruction field decode
    logic [6:0]  opc_w;
    logic [2:0]  f3_w;
    logic [6:0]  f7_w;
    logic        is_r_w;
    logic        is_i_w;
    logic        is_shift_w;
    logic [31:0] op_b_w;
    logic [4:0]  shamt_w;
    logic        legal_d;
    logic [31:0] alu_d;
    logic        go_serial_d;
    logic        unused_rs1_field;

    assign opc_w      = instr[6:0];
    assign f3_w       = instr[14:12];
    assign f7_w       = instr[31:25];
    assign is_r_w     = (opc_w == 7'h33);
    assign is_i_w     = (opc_w == 7'h13);
    assign is_shift_w = (f3_w == 3'd1) || (f3_w == 3'd5);
    assign op_b_w     = is_r_w ? rs2_val : {{20{instr[31]}}, instr[31:20]};
    assign shamt_w    = op_b_w[4:0];
    // Register numbers arrive as values, so the rs1 field is not needed here.
    assign unused_rs1_field = ^instr[19:15];

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = vld_q;
    assign result    = result_q;
    assign rd_addr   = rd_q;
    assign rd_we     = we_q;
    assign illegal   = ill_q;

    // Legality of the opcode/funct combination
    always_comb begin
        legal_d = 1'b0;
        if (is_r_w) begin
            legal_d = (f7_w == 7'h00) ||
                      ((f7_w == 7'h20) && ((f3_w == 3'd0) || (f3_w == 3'd5)));
        end else if (is_i_w) begin
            case (f3_w)
                3'd1:    legal_d = (f7_w == 7'h00);
                3'd5:    legal_d = (f7_w == 7'h00) || (f7_w == 7'h20);
                default: legal_d = 1'b1;
            endcase
        end
    end

    // Single-cycle ALU; f7[5] selects sub (R-type only) and sra/srai
    always_comb begin
        alu_d = 32'd0;
        case (f3_w)
            3'd0: alu_d = (is_r_w && f7_w[5]) ? rs1_val - op_b_w : rs1_val + op_b_w;
            3'd1: alu_d = rs1_val << shamt_w;
            3'd2: alu_d = {31'd0, $signed(rs1_val) < $signed(op_b_w)};
            3'd3: alu_d = {31'd0, rs1_val < op_b_w};
            3'd4: alu_d = rs1_val ^ op_b_w;
            3'd5: alu_d = f7_w[5] ? 32'($signed(rs1_val) >>> shamt_w) : rs1_val >> shamt_w;
            3'd6: alu_d = rs1_val | op_b_w;
            3'd7: alu_d = rs1_val & op_b_w;
            default: alu_d = 32'd0;
        endcase
    end

    // Only legal, nonzero-amount shifts take the iterative path
    assign go_serial_d = (SERIAL_SHIFT != 0) && legal_d && is_shift_w && (shamt_w != 5'd0);

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= 32'd0;
            rd_q     <= 5'd0;
            we_q     <= 1'b0;
            ill_q    <= 1'b0;
            vld_q    <= 1'b0;
            cnt_q    <= 5'd0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        rd_q  <= instr[11:7];
                        ill_q <= !legal_d;
                        we_q  <= legal_d && (instr[11:7] != 5'd0);
                        if (go_serial_d) begin
                            result_q <= rs1_val;
                            cnt_q    <= shamt_w;
                            left_q   <= (f3_w == 3'd1);
                            arith_q  <= f7_w[5];
                            state_q  <= S_SHIFT;
                        end else begin
                            result_q <= legal_d ? alu_d : 32'd0;
                            vld_q    <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    if (left_q)
                        result_q <= {result_q[30:0], 1'b0};
                    else
                        result_q <= {arith_q & result_q[31], result_q[31:1]};
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        vld_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: fixed vector table, hand-written
// backpressure/reset sequences and random ops against a behavioural model.
module tb_alu_exec_seq;

    localparam int SER = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_seq #(.SERIAL_SHIFT(SER)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        we;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'h13};
    endfunction

    // Behavioural reference: RV32I semantics straight from the instruction rules
    task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rb,
                         output logic [31:0] res, output logic we, output logic ill, output int lat);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] b;
        int          sh;
        logic        ok;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        b   = (opc == 7'h33) ? rb : {{20{ins[31]}}, ins[31:20]};
        sh  = int'(b[4:0]);
        if (opc == 7'h33)
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (opc == 7'h13)
            ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                 (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else
            ok = 1'b0;
        res = 32'd0;
        if (ok) begin
            case (f3)
                3'd0: res = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
                3'd1: res = a << sh;
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end
        ill = !ok;
        we  = ok && (ins[11:7] != 5'd0);
        lat = (ok && SER != 0 && (f3 == 3'd1 || f3 == 3'd5) && sh != 0) ? sh + 1 : 1;
    endtask

    // Issue one op, measure latency, check outputs, hold briefly, then accept
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res_e, input logic we_e, input logic ill_e,
                          input int lat_e, input string nm);
        int n;
        int hold;
        @(negedge clk);
        chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        instr    = ins;
        rs1_val  = a;
        rs2_val  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr    = $urandom;
        rs1_val  = $urandom;
        rs2_val  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 64);
        chk({nm, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, ".latency"}, n, lat_e);
        chk({nm, ".result"}, result, res_e);
        chk({nm, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, ins[11:7]});
        chk({nm, ".rd_we"}, {31'd0, rd_we}, {31'd0, we_e});
        chk({nm, ".illegal"}, {31'd0, illegal}, {31'd0, ill_e});
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(negedge clk);
            chk({nm, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, ".hold_result"}, result, res_e);
            chk({nm, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r_e;
        logic        we_e;
        logic        ill_e;
        int          lat_e;
        logic [31:0] ins;
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          sel;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;

        tv[0]  = '{enc_r(7'h00, 3'd0, 5'd5), 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1};
        tv[1]  = '{enc_r(7'h20, 3'd0, 5'd5), 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFE, 1'b1, 1'b0, 1};
        tv[2]  = '{enc_i(12'hFFF, 3'd0, 5'd6), 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
        tv[3]  = '{enc_i(12'h001, 3'd2, 5'd7), 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1, 1'b0, 1};
        tv[4]  = '{enc_i(12'h001, 3'd3, 5'd7), 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b0, 1};
        tv[5]  = '{enc_i(12'h404, 3'd5, 5'd8), 32'h80000000, 32'd0, 32'hF8000000, 1'b1, 1'b0, 5};
        tv[6]  = '{enc_i(12'h400, 3'd5, 5'd8), 32'h80000000, 32'd0, 32'h80000000, 1'b1, 1'b0, 1};
        tv[7]  = '{32'h00002283, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1};
        tv[8]  = '{enc_r(7'h20, 3'd4, 5'd9), 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 1'b0, 1'b1, 1};
        tv[9]  = '{enc_r(7'h00, 3'd0, 5'd0), 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1};
        tv[10] = '{enc_i(12'h023, 3'd1, 5'd4), 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1};
        tv[11] = '{enc_r(7'h00, 3'd5, 5'd10), 32'h80, 32'h23, 32'h10, 1'b1, 1'b0, 4};
        tv[12] = '{enc_r(7'h00, 3'd1, 5'd11), 32'd1, 32'd31, 32'h80000000, 1'b1, 1'b0, 32};
        tv[13] = '{enc_r(7'h00, 3'd4, 5'd12), 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b1, 1'b0, 1};
        tv[14] = '{enc_r(7'h00, 3'd2, 5'd13), 32'h80000000, 32'd1, 32'd1, 1'b1, 1'b0, 1};
        tv[15] = '{enc_r(7'h20, 3'd5, 5'd14), 32'h80000010, 32'd1, 32'hC0000008, 1'b1, 1'b0, 2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst.rd_we", {31'd0, rd_we}, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;

        // Fixed vectors
        for (int i = 0; i < 16; i++)
            run_op(tv[i].ins, tv[i].a, tv[i].b, tv[i].res, tv[i].we, tv[i].ill, tv[i].lat,
                   $sformatf("vec%0d", i));

        // Backpressure: second request waits until after the out handshake
        @(negedge clk);
        in_valid = 1'b1; instr = enc_r(7'h00, 3'd0, 5'd3); rs1_val = 32'd10; rs2_val = 32'd20;
        @(posedge clk);
        #1;
        instr = enc_r(7'h00, 3'd6, 5'd4); rs1_val = 32'hA0; rs2_val = 32'h0B;
        repeat (5) begin
            @(negedge clk);
            chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.result", result, 32'd30);
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp.after_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("bp.after_hs_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.second_valid", {31'd0, out_valid}, 32'd1);
        chk("bp.second_result", result, 32'hAB);
        chk("bp.second_rd", {27'd0, rd_addr}, 32'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a 20-step shift
        @(negedge clk);
        in_valid = 1'b1; instr = enc_r(7'h00, 3'd1, 5'd3); rs1_val = 32'd1; rs2_val = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid.busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid.rd_we", {31'd0, rd_we}, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid.no_output", {31'd0, out_valid}, 32'd0);
        end
        run_op(enc_r(7'h00, 3'd0, 5'd2), 32'd100, 32'd23, 32'd123, 1'b1, 1'b0, 1, "rstmid.add");

        // Reset wins over a simultaneous request
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; instr = enc_r(7'h00, 3'd0, 5'd2);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rstin.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstin.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("rstin.still_idle", {31'd0, out_valid}, 32'd0);

        // Random ops against the reference model
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            ins = $urandom;
            if (sel <= 3)
                ins = {f7, ins[24:15], f3, ins[11:7], 7'h33};
            else if (sel <= 7)
                ins = {((f3 == 3'd1 || f3 == 3'd5) ? f7 : ins[31:25]), ins[24:15], f3, ins[11:7], 7'h13};
            else if (sel == 9)
                ins = {ins[31:15], f3, ins[11:7], 7'h33};
            rs1_val = $urandom;
            model(ins, rs1_val, rs1_val ^ 32'h5A5A_1234 + 32'(k), r_e, we_e, ill_e, lat_e);
            run_op(ins, rs1_val, rs1_val ^ 32'h5A5A_1234 + 32'(k), r_e, we_e, ill_e, lat_e,
                   $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Execute-stage sequencer for RV32I integer ops: accepts one R-type (opcode 0x33) or I-type ALU (opcode 0x13) instruction plus operand values over a valid/ready handshake.
- Decodes funct3/funct7, selects rs2 vs sign-extended immediate, computes the result and returns it with destination register and write enable over a second valid/ready handshake.
- Shifts run on an iterative 1-bit-per-cycle shifter to save area; all other ops complete in one cycle. Sits between decode and writeback.

Parameters:
- SERIAL_SHIFT, 1, 1 = iterative shifter (shamt cycles); 0 = single-cycle barrel shift (shift latency equals non-shift latency).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction and operands valid
- in_ready  out  1  block can accept; high only in IDLE
- instr  in  32  full instruction word
- rs1_val  in  32  rs1 register value
- rs2_val  in  32  rs2 register value (ignored for I-type)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  writeback accepts result
- result  out  32  ALU result
- rd_addr  out  5  instr[11:7] of the accepted instruction
- rd_we  out  1  writeback enable = !illegal && rd_addr != 0
- illegal  out  1  unsupported opcode/funct combination

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; out_valid=0, result=0, rd_addr=0, rd_we=0, illegal=0; internal shift counter and operand registers cleared. Any in-flight operation is discarded, with no output for it.
- in_ready = (state==IDLE), combinational from state only. Acceptance = in_valid && in_ready at a posedge; instr, rs1_val and operand B are captured then.
- Operand B: R-type uses rs2_val; I-type uses sign-extend(instr[31:20]). Shift amount = B[4:0].
- States:
  - IDLE: on acceptance, go to SHIFT if the op is a shift with SERIAL_SHIFT=1 and shamt!=0; otherwise go to DONE.
  - SHIFT: shift the working register 1 bit per cycle and decrement the counter; go to DONE when the counter hits 0.
  - DONE: out_valid=1; on out_ready go to IDLE.
- Latency: accept at edge T gives out_valid from T+1 for non-shift ops, for shamt=0, and for any op with SERIAL_SHIFT=0. A serial shift by N gives out_valid from T+1+N.
- No overlap: the next instruction can be accepted at the edge after the output handshake, so minimum issue interval is 2 cycles.
- Output stability: result, rd_addr, rd_we and illegal are stable while out_valid=1 and out_ready=0.
- funct3 map: 0 add/sub, 1 sll, 2 slt (signed), 3 sltu, 4 xor, 5 srl/sra, 6 or, 7 and.
  - SLT/SLTU write 32'd1 or 32'd0.
  - All arithmetic wraps mod 2^32 with no overflow flag.
  - SRA replicates bit 31 on every serial step.
- Legality:
  - R-type: funct7=0x00 is legal for any funct3; funct7=0x20 is legal only for funct3 0 (sub) and 5 (sra); anything else is illegal.
  - I-type: funct3=1 requires instr[31:25]=0x00; funct3=5 requires instr[31:25] of 0x00 (srli) or 0x20 (srai); other funct3 are always legal. There is no subi; funct3=0 is addi regardless of imm.
  - Any other opcode is illegal.
- Illegal handling: illegal=1, result=0, rd_we=0; the op takes the non-shift path (DONE at T+1).
- rd_addr=0 with a legal op: result is computed, rd_we=0.
- Reset asserted together with in_valid or out_ready: reset wins and nothing is accepted.

Test Plan:
- ADD, then SUB (R, rs1=0x7FFFFFFF, rs2=1): ADD gives result=0x80000000 at T+1, rd_we=1; SUB with funct7=0x20 gives 0x7FFFFFFE.
- ADDI imm=0xFFF (-1), rs1=0: result=0xFFFFFFFF. SLTI imm=1, rs1=0xFFFFFFFF: result=1. SLTIU same operands: result=0.
- SRAI shamt=4, rs1=0x80000000, SERIAL_SHIFT=1: out_valid first high at T+5, result=0xF8000000. Same with shamt=0: out_valid at T+1, result=0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles. in_ready stays 0, out_valid and result stay stable, and a second in_valid is not accepted until the cycle after the out handshake.
- Illegal: opcode 0x03, then R-type funct3=4 with funct7=0x20. Each gives illegal=1, rd_we=0, result=0 at T+1. A legal op with rd=x0 gives rd_we=0.
- Reset mid-SHIFT (SLL shamt=20, rst at T+6): next cycle state=IDLE, out_valid=0, in_ready=1. A subsequent ADD completes normally with correct latency.
